// File: rtl/gpa_spi_multi_ser_if.sv
// Bus bundle between the gradient memory core (master) and the SPI serialiser (slave).
interface gpa_spi_multi_ser_if #(
  parameter int CHANNELS = 4,
  parameter int WORD_W   = 24
);
  logic [CHANNELS*WORD_W-1:0] data_i;
  logic                       valid_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       overrun_o;
  logic                       fhd_clk_o;
  logic                       fhd_sdo_o;
  logic                       fhd_ssn_o;
  logic                       fhd_sdi_i;
  logic [CHANNELS*WORD_W-1:0] rdata_o;

  modport master (
    output data_i, valid_i, fhd_sdi_i,
    input  busy_o, done_o, overrun_o, fhd_clk_o, fhd_sdo_o, fhd_ssn_o, rdata_o
  );

  modport slave (
    input  data_i, valid_i, fhd_sdi_i,
    output busy_o, done_o, overrun_o, fhd_clk_o, fhd_sdo_o, fhd_ssn_o, rdata_o
  );
endinterface

// File: rtl/gpa_spi_multi_ser.sv
// Multi-channel SPI serialiser: one chip-select frame per channel word, MSB first, SPI mode 1.
// Optional SDI readback is built only when GPA_SPI_READBACK_EN is defined.
//
// state | meaning
// IDLE  | waiting for valid_i
// SETUP | ssn low, sclk low, CLK_DIV cycles before the first edge
// SHIFT | WORD_W bit periods, sclk high then low, CLK_DIV cycles each
// HOLD  | ssn low, sclk low, LSB held for CLK_DIV cycles
// GAP   | ssn high for CS_GAP cycles, then next channel or finish
module gpa_spi_multi_ser #(
  parameter int CHANNELS = 4,
  parameter int WORD_W   = 24,
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 2
) (
  input logic                clk,
  input logic                rst_n,
  gpa_spi_multi_ser_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BIT_W   = $clog2(WORD_W);
  localparam int CNT_MAX = (2*CLK_DIV > CS_GAP) ? 2*CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CLK_DIV-1);
  localparam logic [CNT_W-1:0] BIT_LD   = CNT_W'(2*CLK_DIV-1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP-1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WORD_W-1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS-1);
  localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WORD_W-1:0] shadow_q [CHANNELS];
  logic              load;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              ssn_q, ssn_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          load    = 1'b1;
          ovr_d   = 1'b0;
          ch_d    = '0;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = BIT_LD;
          bit_d   = BIT_MSB;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (bit_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = SETUP_LD;
        end else begin
          bit_d = bit_q - BIT_ONE;
          cnt_d = BIT_LD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (ch_q == CH_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          ch_d    = ch_q + CH_ONE;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.valid_i && (state_q != S_IDLE)) ovr_d = 1'b1;

    // Pin outputs are registered from next-state so sclk/sdo/ssn change together and never glitch.
    sclk_d = (state_d == S_SHIFT) && (cnt_d >= HALF);
    sdo_d  = ((state_d == S_SHIFT) || (state_d == S_HOLD)) ? shadow_q[ch_d][bit_d] : 1'b0;
    ssn_d  = !((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      ssn_q   <= 1'b1;
      busy_q  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) shadow_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      ssn_q   <= ssn_d;
      busy_q  <= busy_d;
      if (load) begin
        for (int k = 0; k < CHANNELS; k++) shadow_q[k] <= bus.data_i[k*WORD_W +: WORD_W];
      end
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.overrun_o = ovr_q;
  assign bus.fhd_clk_o = sclk_q;
  assign bus.fhd_sdo_o = sdo_q;
  assign bus.fhd_ssn_o = ssn_q;

`ifdef GPA_SPI_READBACK_EN
  logic [WORD_W-1:0]          rd_shift_q;
  logic [WORD_W-1:0]          rdata_q [CHANNELS];
  logic [CHANNELS*WORD_W-1:0] rdata_pk;
  logic                       sclk_fall;
  logic                       commit;

  // Readback word becomes visible only when the frame completes its HOLD phase.
  assign sclk_fall = sclk_q && !sclk_d;
  assign commit    = (state_q == S_HOLD) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_shift_q <= '0;
      for (int k = 0; k < CHANNELS; k++) rdata_q[k] <= '0;
    end else begin
      if (sclk_fall) rd_shift_q <= {rd_shift_q[WORD_W-2:0], bus.fhd_sdi_i};
      if (commit) rdata_q[ch_q] <= rd_shift_q;
    end
  end

  always_comb begin
    rdata_pk = '0;
    for (int k = 0; k < CHANNELS; k++) rdata_pk[k*WORD_W +: WORD_W] = rdata_q[k];
  end

  assign bus.rdata_o = rdata_pk;
`else
  assign bus.rdata_o = '0;
`endif
endmodule

// File: tb/tb_gpa_spi_multi_ser.sv
// Directed bench for gpa_spi_multi_ser: default 4x24 instance plus a 2x16 loopback instance.
module tb_gpa_spi_multi_ser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpa_spi_multi_ser_if #(.CHANNELS(4), .WORD_W(24)) bus1 ();
  gpa_spi_multi_ser #(.CHANNELS(4), .WORD_W(24), .CLK_DIV(2), .CS_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  gpa_spi_multi_ser_if #(.CHANNELS(2), .WORD_W(16)) bus2 ();
  gpa_spi_multi_ser #(.CHANNELS(2), .WORD_W(16), .CLK_DIV(1), .CS_GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
  assign bus2.fhd_sdi_i = bus2.fhd_sdo_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor of the main SPI port, sampled on the falling clk edge.
  logic [23:0] cap = '0;
  int          cur_rises = 0;
  int          gap_run = 0;
  int          busy_cnt = 0;
  int          bad_sclk = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_ssn = 1'b1;
  logic [23:0] words[$];
  int          rises_q[$];
  int          gaps[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      cap = '0; cur_rises = 0; gap_run = 0; prev_sclk = 1'b0; prev_ssn = 1'b1;
    end else begin
      if (bus1.fhd_clk_o && !prev_sclk) begin
        cap = {cap[22:0], bus1.fhd_sdo_o};
        cur_rises++;
      end
      if (bus1.fhd_clk_o && bus1.fhd_ssn_o) bad_sclk++;
      if (bus1.fhd_ssn_o && !prev_ssn) begin
        words.push_back(cap);
        rises_q.push_back(cur_rises);
        cap = '0;
        cur_rises = 0;
      end
      if (bus1.busy_o) busy_cnt++;
      if (bus1.busy_o && bus1.fhd_ssn_o) gap_run++;
      else begin
        if (gap_run > 0 && bus1.busy_o) gaps.push_back(gap_run);
        gap_run = 0;
      end
      prev_sclk = bus1.fhd_clk_o;
      prev_ssn  = bus1.fhd_ssn_o;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [95:0] d);
    bus1.data_i  = d;
    bus1.valid_i = 1'b1;
    tick;
    bus1.valid_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus1.done_o) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    n_cmp++; if (bus1.fhd_ssn_o !== 1'b1) begin n_bad++; $display("FAIL reset_ssn: got %b expected 1", bus1.fhd_ssn_o); end
    n_cmp++; if (bus1.fhd_clk_o !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b expected 0", bus1.fhd_clk_o); end
    n_cmp++; if (bus1.fhd_sdo_o !== 1'b0) begin n_bad++; $display("FAIL reset_sdo: got %b expected 0", bus1.fhd_sdo_o); end
    n_cmp++; if (bus1.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus1.busy_o); end
    n_cmp++; if (bus1.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus1.done_o); end
    n_cmp++; if (bus1.overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", bus1.overrun_o); end
    n_cmp++; if (bus1.rdata_o !== 96'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", bus1.rdata_o); end
    n_cmp++; if (bus2.fhd_ssn_o !== 1'b1) begin n_bad++; $display("FAIL reset_ssn2: got %b expected 1", bus2.fhd_ssn_o); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [23:0] exp_w [4];
    int wb, gb, bb, sb;
    bit ok, rises_ok;
    exp_w = '{24'h800001, 24'h0000FF, 24'h123456, 24'hA5A5A5};
    wb = words.size(); gb = gaps.size(); bb = busy_cnt; sb = bad_sclk;
    start({24'hA5A5A5, 24'h123456, 24'h0000FF, 24'h800001});
    n_cmp++; if (bus1.busy_o !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start: got %b expected 1", bus1.busy_o); end
    n_cmp++; if (bus1.fhd_ssn_o !== 1'b0) begin n_bad++; $display("FAIL basic_ssn_start: got %b expected 0", bus1.fhd_ssn_o); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_done_timeout: got no done expected done"); end
    n_cmp++; if (bus1.busy_o !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b expected 0", bus1.busy_o); end
    n_cmp++; if (words.size() - wb != 4) begin n_bad++; $display("FAIL basic_frames: got %0d expected 4", words.size() - wb); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (words[wb+k] !== exp_w[k]) begin n_bad++; $display("FAIL basic_word%0d: got %h expected %h", k, words[wb+k], exp_w[k]); end
      end
      rises_ok = 1'b1;
      for (int k = 0; k < 4; k++) if (rises_q[wb+k] != 24) rises_ok = 1'b0;
      n_cmp++; if (!rises_ok) begin n_bad++; $display("FAIL basic_sclk_rises: got %0d on frame0 expected 24 per frame", rises_q[wb]); end
    end
    n_cmp++; if (busy_cnt - bb != 408) begin n_bad++; $display("FAIL basic_busy_len: got %0d expected 408", busy_cnt - bb); end
    n_cmp++; if (gaps.size() - gb != 3) begin n_bad++; $display("FAIL basic_gap_count: got %0d expected 3", gaps.size() - gb); end
    else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if (gaps[gb+k] != 2) begin n_bad++; $display("FAIL basic_gap%0d: got %0d expected 2", k, gaps[gb+k]); end
      end
    end
    n_cmp++; if (bad_sclk != sb) begin n_bad++; $display("FAIL basic_sclk_outside_frame: got %0d expected 0", bad_sclk - sb); end
    tick;
    n_cmp++; if (bus1.done_o !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b expected 0", bus1.done_o); end
  endtask

  task automatic test_overrun;
    logic [23:0] exp_w [4];
    int wb;
    bit ok, hit;
    exp_w = '{24'h444444, 24'h333333, 24'h222222, 24'h111111};
    wb = words.size();
    start({24'h111111, 24'h222222, 24'h333333, 24'h444444});
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (words.size() - wb == 2 && cur_rises == 5) begin hit = 1'b1; break; end
      tick;
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL overrun_reach_ch2: got timeout expected channel 2 bit 19"); end
    bus1.data_i  = {24'hFFFFFF, 24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC};
    bus1.valid_i = 1'b1;
    tick;
    bus1.valid_i = 1'b0;
    n_cmp++; if (bus1.overrun_o !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b expected 1", bus1.overrun_o); end
    n_cmp++; if (bus1.busy_o !== 1'b1) begin n_bad++; $display("FAIL overrun_busy: got %b expected 1", bus1.busy_o); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL overrun_done_timeout: got no done expected done"); end
    n_cmp++; if (words.size() - wb != 4) begin n_bad++; $display("FAIL overrun_frames: got %0d expected 4", words.size() - wb); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (words[wb+k] !== exp_w[k]) begin n_bad++; $display("FAIL overrun_word%0d: got %h expected %h", k, words[wb+k], exp_w[k]); end
      end
    end
    n_cmp++; if (bus1.overrun_o !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b expected 1", bus1.overrun_o); end
    tick;
    start({24'h000001, 24'h000002, 24'h000003, 24'h000004});
    n_cmp++; if (bus1.overrun_o !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %b expected 0", bus1.overrun_o); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL overrun_clear_done_timeout: got no done expected done"); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp_w [4];
    int wb, bb;
    bit ok;
    exp_w = '{24'h5A5A5A, 24'hFFFFFE, 24'h7FFFFF, 24'h000000};
    start({24'hABCDEF, 24'h13579B, 24'h2468AC, 24'hFEDCBA});
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_first_done_timeout: got no done expected done"); end
    wb = words.size(); bb = busy_cnt;
    bus1.data_i  = {24'h000000, 24'h7FFFFF, 24'hFFFFFE, 24'h5A5A5A};
    bus1.valid_i = 1'b1;
    tick;
    bus1.valid_i = 1'b0;
    n_cmp++; if (bus1.busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b expected 1", bus1.busy_o); end
    n_cmp++; if (bus1.fhd_ssn_o !== 1'b0) begin n_bad++; $display("FAIL b2b_ssn: got %b expected 0", bus1.fhd_ssn_o); end
    n_cmp++; if (bus1.done_o !== 1'b0) begin n_bad++; $display("FAIL b2b_done_drop: got %b expected 0", bus1.done_o); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_second_done_timeout: got no done expected done"); end
    n_cmp++; if (words.size() - wb != 4) begin n_bad++; $display("FAIL b2b_frames: got %0d expected 4", words.size() - wb); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (words[wb+k] !== exp_w[k]) begin n_bad++; $display("FAIL b2b_word%0d: got %h expected %h", k, words[wb+k], exp_w[k]); end
      end
    end
    n_cmp++; if (busy_cnt - bb != 408) begin n_bad++; $display("FAIL b2b_busy_len: got %0d expected 408", busy_cnt - bb); end
    tick;
  endtask

  task automatic test_reset_mid;
    int wb;
    bit ok, hit;
    wb = words.size();
    start({24'hA5A5A5, 24'h123456, 24'h0000FF, 24'h800001});
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (words.size() - wb == 1 && cur_rises == 14) begin hit = 1'b1; break; end
      tick;
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL rstmid_reach_bit10: got timeout expected channel 1 bit 10"); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus1.fhd_ssn_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_ssn: got %b expected 1", bus1.fhd_ssn_o); end
    n_cmp++; if (bus1.fhd_clk_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_sclk: got %b expected 0", bus1.fhd_clk_o); end
    n_cmp++; if (bus1.fhd_sdo_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_sdo: got %b expected 0", bus1.fhd_sdo_o); end
    n_cmp++; if (bus1.busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", bus1.busy_o); end
    tick;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (bus1.busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_resume: got busy %b expected 0", bus1.busy_o); end
    wb = words.size();
    start({24'h0F0F0F, 24'hF0F0F0, 24'h00AA55, 24'hC3C3C3});
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_done_timeout: got no done expected done"); end
    n_cmp++; if (words.size() - wb != 4) begin n_bad++; $display("FAIL rstmid_frames: got %0d expected 4", words.size() - wb); end
    else begin
      n_cmp++; if (words[wb] !== 24'hC3C3C3) begin n_bad++; $display("FAIL rstmid_word0: got %h expected c3c3c3", words[wb]); end
      n_cmp++; if (rises_q[wb] != 24) begin n_bad++; $display("FAIL rstmid_rises0: got %0d expected 24", rises_q[wb]); end
      n_cmp++; if (words[wb+3] !== 24'h0F0F0F) begin n_bad++; $display("FAIL rstmid_word3: got %h expected 0f0f0f", words[wb+3]); end
    end
    tick;
  endtask

  task automatic test_readback;
    logic [31:0] exp_rd;
    bit ok;
`ifdef GPA_SPI_READBACK_EN
    exp_rd = 32'hBEEFC0DE;
`else
    exp_rd = 32'h0;
`endif
    bus2.data_i  = {16'hBEEF, 16'hC0DE};
    bus2.valid_i = 1'b1;
    tick;
    bus2.valid_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bus2.done_o) begin ok = 1'b1; break; end
      tick;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rb_done_timeout: got no done expected done"); end
    n_cmp++; if (bus2.rdata_o !== exp_rd) begin n_bad++; $display("FAIL rb_rdata: got %h expected %h", bus2.rdata_o, exp_rd); end
    n_cmp++; if (bus1.rdata_o !== 96'h0) begin n_bad++; $display("FAIL rb_rdata_sdi_low: got %h expected 0", bus1.rdata_o); end
    tick;
  endtask

  initial begin
    bus1.data_i    = '0;
    bus1.valid_i   = 1'b0;
    bus1.fhd_sdi_i = 1'b0;
    bus2.data_i    = '0;
    bus2.valid_i   = 1'b0;
    test_reset;
    test_basic;
    test_overrun;
    test_back_to_back;
    test_reset_mid;
    test_readback;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
